// File: rtl/note_sequencer.sv
// Step sequencer for one nco voice: plays (frequency, duration) steps from a small
// pattern memory, with durations counted in audio sample ticks.
module note_sequencer #(
    parameter int unsigned FREQ_BITS = 22,
    parameter int unsigned DUR_BITS  = 16,
    parameter int unsigned DEPTH     = 16,
    localparam int unsigned ADDR_BITS = $clog2(DEPTH)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [FREQ_BITS-1:0] wr_freq,
    input  logic [DUR_BITS-1:0]  wr_dur,
    input  logic [ADDR_BITS:0]   length,
    input  logic                 loop,
    input  logic                 start,
    input  logic                 stop,
    output logic [FREQ_BITS-1:0] freq,
    output logic                 enable,
    output logic                 busy,
    output logic [ADDR_BITS-1:0] step,
    output logic                 done
);

    localparam int unsigned LEN_BITS = ADDR_BITS + 1;
    localparam int unsigned MEM_BITS = FREQ_BITS + DUR_BITS;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PLAY
    } state_t;

    state_t               state, state_d;
    logic [MEM_BITS-1:0]  mem [DEPTH];
    logic [MEM_BITS-1:0]  rd_data;
    logic [FREQ_BITS-1:0] rd_freq;
    logic [DUR_BITS-1:0]  rd_dur;
    logic [DUR_BITS-1:0]  count, count_d;
    logic [LEN_BITS-1:0]  len_r, len_d;
    logic                 loop_r, loop_d;
    logic [FREQ_BITS-1:0] freq_d;
    logic                 enable_d, busy_d, done_d;
    logic [ADDR_BITS-1:0] step_d;
    logic                 advance;
    logic                 last_step;

    assign rd_freq   = rd_data[MEM_BITS-1:DUR_BITS];
    assign rd_dur    = rd_data[DUR_BITS-1:0];
    assign last_step = ({1'b0, step} == (len_r - LEN_BITS'(1)));

    // Pattern memory; the read address is the next step so data is ready during FETCH.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= {wr_freq, wr_dur};
        end
        rd_data <= mem[step_d];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            freq   <= '0;
            enable <= 1'b0;
            busy   <= 1'b0;
            step   <= '0;
            done   <= 1'b0;
            count  <= '0;
            len_r  <= '0;
            loop_r <= 1'b0;
        end else begin
            state  <= state_d;
            freq   <= freq_d;
            enable <= enable_d;
            busy   <= busy_d;
            step   <= step_d;
            done   <= done_d;
            count  <= count_d;
            len_r  <= len_d;
            loop_r <= loop_d;
        end
    end

    always_comb begin
        state_d  = state;
        freq_d   = freq;
        enable_d = enable;
        step_d   = step;
        done_d   = 1'b0;
        count_d  = count;
        len_d    = len_r;
        loop_d   = loop_r;
        advance  = 1'b0;

        case (state)
            IDLE: begin
                if (start && !stop && (length != '0)) begin
                    state_d = FETCH;
                    step_d  = '0;
                    len_d   = (length > LEN_BITS'(DEPTH)) ? LEN_BITS'(DEPTH) : length;
                    loop_d  = loop;
                end
            end
            FETCH: begin
                if (rd_dur != '0) begin
                    state_d  = PLAY;
                    freq_d   = rd_freq;
                    enable_d = (rd_freq != '0);
                    count_d  = rd_dur;
                end else begin
                    advance = 1'b1;
                end
            end
            PLAY: begin
                if (tick) begin
                    if (count == DUR_BITS'(1)) begin
                        advance = 1'b1;
                    end else begin
                        count_d = count - DUR_BITS'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Step boundary: next step, wrap, or finish.
        if (advance) begin
            if (!last_step) begin
                step_d  = step + ADDR_BITS'(1);
                state_d = FETCH;
            end else if (loop_r) begin
                step_d  = '0;
                state_d = FETCH;
            end else begin
                state_d  = IDLE;
                freq_d   = '0;
                enable_d = 1'b0;
                done_d   = 1'b1;
            end
        end

        if (stop) begin
            state_d  = IDLE;
            freq_d   = '0;
            enable_d = 1'b0;
            done_d   = 1'b0;
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer: output-change events (with tick counts
// between them) are queued as expected at stimulus time and compared as observed.
module tb_note_sequencer;

    localparam int unsigned FREQ_BITS = 22;
    localparam int unsigned DUR_BITS  = 16;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned ADDR_BITS = 4;
    localparam int unsigned FRAC      = 8;

    localparam logic [FREQ_BITS-1:0] F440 = FREQ_BITS'(440 << FRAC);
    localparam logic [FREQ_BITS-1:0] F660 = FREQ_BITS'(660 << FRAC);
    localparam logic [FREQ_BITS-1:0] F880 = FREQ_BITS'(880 << FRAC);
    localparam logic [FREQ_BITS-1:0] F0   = '0;

    typedef struct packed {
        logic [FREQ_BITS-1:0] freq;
        logic                 enable;
        logic                 busy;
        logic                 done;
        logic [7:0]           ticks;
    } ev_t;

    logic                 clock = 1'b0;
    logic                 reset = 1'b1;
    logic                 tick = 1'b0;
    logic                 wr_en = 1'b0;
    logic [ADDR_BITS-1:0] wr_addr = '0;
    logic [FREQ_BITS-1:0] wr_freq = '0;
    logic [DUR_BITS-1:0]  wr_dur = '0;
    logic [ADDR_BITS:0]   length = '0;
    logic                 loop = 1'b0;
    logic                 start = 1'b0;
    logic                 stop = 1'b0;
    logic [FREQ_BITS-1:0] freq;
    logic                 enable;
    logic                 busy;
    logic [ADDR_BITS-1:0] step;
    logic                 done;

    logic [2:0]           div = '0;
    int unsigned          tick_cnt = 0;
    int unsigned          last_cnt = 0;
    logic [FREQ_BITS+2:0] prev_o = '0;
    ev_t                  obs_q[$];
    ev_t                  exp_q[$];
    int                   n_vec = 0;
    int                   n_fail = 0;

    note_sequencer #(
        .FREQ_BITS(FREQ_BITS),
        .DUR_BITS (DUR_BITS),
        .DEPTH    (DEPTH)
    ) dut (
        .clock  (clock),
        .reset  (reset),
        .tick   (tick),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_freq(wr_freq),
        .wr_dur (wr_dur),
        .length (length),
        .loop   (loop),
        .start  (start),
        .stop   (stop),
        .freq   (freq),
        .enable (enable),
        .busy   (busy),
        .step   (step),
        .done   (done)
    );

    always #5 clock = ~clock;

    // Monitor: record every change of the audible outputs and ticks elapsed since the last one.
    always @(posedge clock) begin
        if (tick) tick_cnt++;
        #1;
        if ({freq, enable, busy, done} !== prev_o) begin
            obs_q.push_back('{freq: freq, enable: enable, busy: busy, done: done,
                              ticks: 8'(tick_cnt - last_cnt)});
            last_cnt = tick_cnt;
            prev_o   = {freq, enable, busy, done};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    function automatic ev_t ev(input logic [FREQ_BITS-1:0] f, input logic en, input logic b,
                               input logic d, input int t);
        return '{freq: f, enable: en, busy: b, done: d, ticks: 8'(t)};
    endfunction

    // One clock cycle; tick strobes once every 8 cycles.
    task automatic cycle();
        @(negedge clock);
        tick = (div == 3'd7);
        div  = div + 3'd1;
    endtask

    task automatic sb_clear();
        obs_q.delete();
        exp_q.delete();
        last_cnt = tick_cnt;
        prev_o   = {freq, enable, busy, done};
    endtask

    task automatic write_step(input int a, input logic [FREQ_BITS-1:0] f, input int d);
        cycle();
        wr_en   = 1'b1;
        wr_addr = ADDR_BITS'(a);
        wr_freq = f;
        wr_dur  = DUR_BITS'(d);
        cycle();
        wr_en   = 1'b0;
    endtask

    task automatic kick(input int len, input logic lp);
        cycle();
        sb_clear();
        start  = 1'b1;
        length = (ADDR_BITS + 1)'(len);
        loop   = lp;
        tick   = 1'b0;
        div    = 3'd1;
        cycle();
        start  = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (busy === 1'b0 && done === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_events(input int n, input int max_cycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            cycle();
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        cycle();
        n_vec++;
        if ({freq, enable, busy, step, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, required 0", {freq, enable, busy, step, done});
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            n_vec++;
            if ({freq, enable, busy, done} !== '0) begin
                n_fail++;
                $display("FAIL idle_cycle%0d: got %h, required 0", i, {freq, enable, busy, done});
            end
        end
    endtask

    task automatic test_single();
        bit  ok;
        ev_t e, g;
        write_step(0, F440, 3);
        write_step(1, F880, 2);
        kick(2, 1'b0);
        exp_q.push_back(ev(F0,   1'b0, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F440, 1'b1, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F880, 1'b1, 1'b1, 1'b0, 3));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b1, 2));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b0, 0));
        wait_idle(400, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL single_timeout: got busy=%b, required idle", busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL single_event: got none, required %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL single_event: got %h, required %h", g, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL single_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_loop();
        bit  ok;
        ev_t e, g;
        write_step(0, F440, 3);
        write_step(1, F880, 2);
        kick(2, 1'b1);
        exp_q.push_back(ev(F0, 1'b0, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F440, 1'b1, 1'b1, 1'b0, 0));
        for (int c = 0; c < 3; c++) begin
            exp_q.push_back(ev(F880, 1'b1, 1'b1, 1'b0, 3));
            exp_q.push_back(ev(F440, 1'b1, 1'b1, 1'b0, 2));
        end
        exp_q.push_back(ev(F0, 1'b0, 1'b0, 1'b0, 0));
        wait_events(8, 600, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL loop_timeout: got %0d events, required 8", obs_q.size());
        end
        n_vec++;
        if (step !== 4'd0) begin
            n_fail++;
            $display("FAIL loop_wrap_step: got %0d, required 0", step);
        end
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (3) cycle();
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL loop_event: got none, required %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL loop_event: got %h, required %h", g, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL loop_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_skip();
        bit  ok;
        ev_t e, g;
        write_step(0, F440, 3);
        write_step(1, F880, 0);
        write_step(2, F660, 1);
        kick(3, 1'b0);
        exp_q.push_back(ev(F0,   1'b0, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F440, 1'b1, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F660, 1'b1, 1'b1, 1'b0, 3));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b1, 1));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b0, 0));
        wait_idle(400, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL skip_timeout: got busy=%b, required idle", busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL skip_event: got none, required %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL skip_event: got %h, required %h", g, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL skip_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_ignored_start(input logic with_stop, input int len);
        cycle();
        sb_clear();
        start  = 1'b1;
        stop   = with_stop;
        length = (ADDR_BITS + 1)'(len);
        loop   = 1'b0;
        cycle();
        start  = 1'b0;
        stop   = 1'b0;
        repeat (5) cycle();
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ignored_start_busy(stop=%b,len=%0d): got %b, required 0", with_stop, len, busy);
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL ignored_start_events(stop=%b,len=%0d): got %0d, required 0",
                     with_stop, len, obs_q.size());
        end
    endtask

    task automatic test_start_while_busy();
        bit  ok;
        ev_t e, g;
        write_step(0, F440, 3);
        write_step(1, F880, 2);
        kick(2, 1'b0);
        exp_q.push_back(ev(F0,   1'b0, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F440, 1'b1, 1'b1, 1'b0, 0));
        exp_q.push_back(ev(F880, 1'b1, 1'b1, 1'b0, 3));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b1, 2));
        exp_q.push_back(ev(F0,   1'b0, 1'b0, 1'b0, 0));
        wait_events(2, 100, ok);
        repeat (10) cycle();
        start  = 1'b1;
        length = 5'd1;
        loop   = 1'b1;
        cycle();
        start  = 1'b0;
        cycle();
        n_vec++;
        if (step !== 4'd0) begin
            n_fail++;
            $display("FAIL busy_start_step: got %0d, required 0", step);
        end
        wait_idle(400, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL busy_start_timeout: got busy=%b, required idle", busy);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL busy_start_event: got none, required %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL busy_start_event: got %h, required %h", g, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL busy_start_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    task automatic test_reset_during_play();
        bit ok;
        kick(2, 1'b0);
        wait_events(3, 200, ok);
        repeat (3) cycle();
        reset  = 1'b1;
        start  = 1'b1;
        length = 5'd2;
        cycle();
        reset  = 1'b0;
        start  = 1'b0;
        n_vec++;
        if ({freq, enable, busy, step, done} !== '0) begin
            n_fail++;
            $display("FAIL midplay_reset: got %h, required 0", {freq, enable, busy, step, done});
        end
        cycle();
        n_vec++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midplay_reset_idle: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_length_overflow();
        bit  ok;
        ev_t e, g;
        for (int i = 0; i < DEPTH; i++) begin
            write_step(i, FREQ_BITS'(((i + 1) * 100) << FRAC), 1);
        end
        kick(DEPTH + 1, 1'b0);
        exp_q.push_back(ev(F0, 1'b0, 1'b1, 1'b0, 0));
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(ev(FREQ_BITS'(((i + 1) * 100) << FRAC), 1'b1, 1'b1, 1'b0, (i == 0) ? 0 : 1));
        end
        exp_q.push_back(ev(F0, 1'b0, 1'b0, 1'b1, 1));
        exp_q.push_back(ev(F0, 1'b0, 1'b0, 1'b0, 0));
        wait_idle(1000, ok);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL overflow_timeout: got busy=%b, required idle", busy);
        end
        n_vec++;
        if (step !== 4'd15) begin
            n_fail++;
            $display("FAIL overflow_last_step: got %0d, required 15", step);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL overflow_event: got none, required %h", e);
            end else begin
                g = obs_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL overflow_event: got %h, required %h", g, e);
                end
            end
        end
        n_vec++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_extra: got %0d extra events, required 0", obs_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_loop();
        test_skip();
        test_ignored_start(1'b1, 2);
        test_start_while_busy();
        test_ignored_start(1'b0, 0);
        test_reset_during_play();
        test_length_overflow();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
